// File: rtl/program_loader.sv
// Serial program loader: receives a word count and little-endian words over a
// byte stream and writes them into instruction memory while holding the CPU in reset.
module program_loader #(
  parameter int MEMORY_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN0  = 3'd1;
  localparam logic [2:0] LEN1  = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;

  localparam logic [16:0] DEPTH = 17'(MEMORY_DEPTH);

  logic [2:0]  state;
  logic [15:0] word_count;
  logic [15:0] word_index;
  logic [15:0] next_index;
  logic [15:0] new_count;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic        accept;

  assign rx_ready   = (state == LEN0) || (state == LEN1) || (state == DATA);
  assign accept     = rx_ready && rx_valid;
  assign busy       = rx_ready || (state == WRITE);
  assign cpu_reset  = busy || (state == ERR);
  assign mem_we     = (state == WRITE);
  assign new_count  = {rx_data, word_count[7:0]};
  assign next_index = word_index + 16'd1;

  // The first three bytes of a word collect in word_buf; the fourth completes the
  // word straight into the registered write port so it stays stable until the next write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word_count <= '0;
      word_index <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_index <= '0;
            byte_cnt   <= '0;
          end
        end
        LEN0: begin
          if (accept) begin
            word_count[7:0] <= rx_data;
            state           <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            word_count <= new_count;
            byte_cnt   <= '0;
            if (new_count == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if ({1'b0, new_count} > DEPTH) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word_buf <= {rx_data, word_buf[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state     <= WRITE;
              mem_wdata <= {rx_data, word_buf};
              mem_addr  <= {14'd0, word_index, 2'b00};
            end
          end
        end
        WRITE: begin
          word_index <= next_index;
          if (next_index == word_count) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader: a queue-based model predicts
// every memory write from the byte stream, and a monitor checks each write strobe.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [7:0]  stream[$];
  logic [31:0] expAddrQ[$];
  logic [31:0] expDataQ[$];
  logic [31:0] lastAddr = '0;
  logic [31:0] lastData = '0;
  bit          monitorOn = 1'b0;

  program_loader #(.MEMORY_DEPTH(256)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every write must match the oldest predicted write; between writes the port holds.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (mem_we) begin
        checkOutput("readyInWrite", {31'd0, rx_ready}, 32'd0);
        if (expAddrQ.size() == 0) begin
          checkOutput("unexpectedWe", {31'd0, mem_we}, 32'd0);
        end else begin
          checkOutput("writeAddr", mem_addr, expAddrQ[0]);
          checkOutput("writeData", mem_wdata, expDataQ[0]);
          lastAddr = expAddrQ.pop_front();
          lastData = expDataQ.pop_front();
        end
      end else begin
        checkOutput("addrHold", mem_addr, lastAddr);
        checkOutput("dataHold", mem_wdata, lastData);
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    lastAddr = '0;
    lastData = '0;
    expAddrQ.delete();
    expDataQ.delete();
  endtask

  task automatic checkIdleOutputs(input string tag);
    @(negedge clk);
    checkOutput({tag, ".outs"},
                {24'd0, rx_ready, mem_we, cpu_reset, busy, done, error, 2'b00}, 32'd0);
    checkOutput({tag, ".addr"}, mem_addr, 32'd0);
    checkOutput({tag, ".data"}, mem_wdata, 32'd0);
  endtask

  task automatic startPulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic buildStream(input int n);
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    if (n <= 256)
      for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
  endtask

  // Expected writes straight from the stream format: word i lands at byte address 4*i.
  task automatic modelLoad();
    int n;
    n = {16'd0, stream[1], stream[0]};
    if (n > 0 && n <= 256)
      for (int i = 0; i < n; i++) begin
        expAddrQ.push_back(32'(i * 4));
        expDataQ.push_back({stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]});
      end
  endtask

  task automatic sendRange(input int first, input int last, input bit gaps);
    int budget;
    for (int k = first; k <= last; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = stream[k];
      budget   = 50;
      while (!rx_ready && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (!rx_ready) begin
        checkOutput("readyTimeout", {31'd0, rx_ready}, 32'd1);
        rx_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic finishLoad(input string tag, input bit expDone, input bit expErr);
    repeat (3) @(negedge clk);
    checkOutput({tag, ".done"}, {31'd0, done}, {31'd0, expDone});
    checkOutput({tag, ".error"}, {31'd0, error}, {31'd0, expErr});
    checkOutput({tag, ".cpuReset"}, {31'd0, cpu_reset}, {31'd0, expErr});
    checkOutput({tag, ".busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, ".pending"}, 32'(expAddrQ.size()), 32'd0);
  endtask

  task automatic runStream(input string tag, input bit gaps);
    int n;
    n = {16'd0, stream[1], stream[0]};
    modelLoad();
    startPulse();
    sendRange(0, stream.size() - 1, gaps);
    finishLoad(tag, n <= 256, n > 256);
  endtask

  task automatic applyStimulus(input string tag, input int n, input bit gaps);
    buildStream(n);
    runStream(tag, gaps);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkIdleOutputs("reset");
    monitorOn = 1'b1;

    // Bytes offered in IDLE must not be consumed.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      checkOutput("idleReady", {31'd0, rx_ready}, 32'd0);
    end
    rx_valid = 1'b0;

    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'hFF, 8'hFF, 8'h00, 8'h08};
    runStream("twoWords", 1'b0);

    buildStream(0);
    runStream("zeroCount", 1'b0);

    stream = '{8'h01, 8'h01};
    runStream("tooLong", 1'b0);
    applyStimulus("afterErr", 2, 1'b0);

    applyStimulus("gappy3", 3, 1'b1);
    applyStimulus("maxDepth", 256, 1'b0);

    // Reset partway into word 1, together with start and rx_valid.
    buildStream(2);
    startPulse();
    sendRange(0, 3, 1'b0);
    doReset();
    checkIdleOutputs("midReset");
    applyStimulus("postReset", 2, 1'b1);

    // A start pulse during DATA must not disturb the load in progress.
    buildStream(1);
    modelLoad();
    startPulse();
    sendRange(0, 3, 1'b0);
    startPulse();
    @(negedge clk);
    checkOutput("startInData.busy", {31'd0, busy}, 32'd1);
    sendRange(4, 5, 1'b0);
    finishLoad("startInData", 1'b1, 1'b0);

    for (int r = 0; r < 6; r++)
      applyStimulus("random", $urandom_range(1, 8), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 256, giving the instruction memory capacity in 32-bit words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to begin a load.
REQ-005 SHALL have port rx_data, input, 8 bits: incoming byte from the serial front end.
REQ-006 SHALL have port rx_valid, input, 1 bit: rx_data holds a valid byte.
REQ-007 SHALL have port rx_ready, output, 1 bit: the loader can accept a byte this cycle.
REQ-008 SHALL have port mem_we, output, 1 bit: instruction memory write strobe.
REQ-009 SHALL have port mem_addr, output, 32 bits: byte address of the write, always word-aligned.
REQ-010 SHALL have port mem_wdata, output, 32 bits: instruction word to write.
REQ-011 SHALL have port cpu_reset, output, 1 bit: holds the processor in reset during a load.
REQ-012 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 SHALL have port done, output, 1 bit: the last load completed; sticky.
REQ-014 SHALL have port error, output, 1 bit: the last load was rejected; sticky.

Function
REQ-015 SHALL implement the states IDLE, LEN0, LEN1, DATA, WRITE, DONE and ERR.
REQ-016 SHALL accept a byte only on a cycle where rx_valid and rx_ready are both high.
REQ-017 SHALL drive rx_ready high only in LEN0, LEN1 and DATA.
REQ-018 SHALL use this stream format: a 16-bit word count N, low byte first, then 4N bytes, each word little-endian (first byte goes to bits 7:0).
REQ-019 SHALL transition on start from IDLE, DONE or ERR to LEN0, clear done, error and the word index, and ignore start in every other state.
REQ-020 SHALL latch the count low byte in LEN0 and move to LEN1 on acceptance.
REQ-021 SHALL latch the count high byte in LEN1 and then move, on that acceptance, to DONE if N=0, to ERR if N>MEMORY_DEPTH, and to DATA otherwise.
REQ-022 SHALL shift bytes into a 32-bit assembly register in DATA, using a 2-bit byte counter.
REQ-023 SHALL move from DATA to WRITE on acceptance of the 4th byte of a word.
REQ-024 SHALL assert mem_we for exactly one cycle in WRITE, with mem_addr = word_index*4 and mem_wdata = the assembled word.
REQ-025 SHALL increment word_index on leaving WRITE, then go to DONE if word_index+1 = N and to DATA otherwise.
REQ-026 SHALL hold mem_we low in all states other than WRITE, and hold mem_addr and mem_wdata stable while mem_we is low.
REQ-027 SHALL drive busy high in LEN0, LEN1, DATA and WRITE.
REQ-028 SHALL drive cpu_reset = busy OR (state==ERR); the processor runs in IDLE and DONE.
REQ-029 SHALL set done on entry to DONE and hold it until the next start or reset.
REQ-030 SHALL set error on entry to ERR and hold it until the next start or reset; no memory write occurs for a rejected load.
REQ-031 SHALL ignore rx_valid outside LEN0, LEN1 and DATA, with no internal state change.
REQ-032 SHALL size word_index at 16 bits, and the address computation SHALL never wrap, because N≤MEMORY_DEPTH is guaranteed by the ERR check.
REQ-033 SHALL complete a load of N words in exactly 4N+2 accepted bytes plus N WRITE cycles.

Reset
REQ-034 SHALL, on reset high at a rising edge, enter IDLE from any state, including mid-word or mid-header, and discard any partial word.
REQ-035 SHALL hold these output values in reset and IDLE: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=0, busy=0, done=0, error=0.
REQ-036 SHALL give reset priority over start and rx_valid in the same cycle.

Verification
REQ-037 Scenario: start, then bytes 02 00 | 13 00 00 20 | FF FF 00 08 -> WRITE addr 0x0 data 0x20000013, then addr 0x4 data 0x0800FFFF; done=1, cpu_reset=0; exactly 2 mem_we pulses.
REQ-038 Scenario: start, then bytes 00 00 -> DONE immediately after the second byte, no mem_we, done=1.
REQ-039 Scenario: start, then count 0x0101 (257 > 256) -> ERR, error=1, cpu_reset=1, no mem_we; a later start clears error and a valid load succeeds.
REQ-040 Scenario: rx_valid toggled randomly (about 50% of cycles) during a 3-word load -> data and addresses identical to the back-to-back case; rx_ready=0 during each WRITE cycle.
REQ-041 Scenario: reset asserted after 2 data bytes of word 1 -> all outputs at reset values next cycle; a new start then loads from addr 0 correctly.
REQ-042 Scenario: start pulsed while in DATA, and rx_valid with bytes in IDLE -> both ignored; word_index unchanged and no byte consumed.
